uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer between the UART receiver and the peripheral bus register file. Captures each byte strobed by the receiver's one-cycle ready pulse into a 2^DEPTH_LOG2-entry FIFO and presents it to the CPU read port in first-word-fall-through form. Also keeps sticky overrun, parity and framing flags and drives level and timeout interrupt requests to the interrupt controller.

## Interface
- DEPTH_LOG2, 4, log2 of FIFO depth; legal range 2..6 (4..64 entries)
- Clock  input  1  system clock; all logic on rising edge
- Reset  input  1  asynchronous, active-low
- RxReady  input  1  one-cycle strobe from receiver; RxData valid in the same cycle
- RxData  input  8  received byte (bit 7 = 0 for 7-bit frames, stored as given)
- RxParityErr  input  1  one-cycle parity-error pulse from receiver
- RxFrameErr  input  1  one-cycle framing-error pulse from receiver
- RdEn  input  1  pop head entry this cycle; ignored when Empty=1
- Flush  input  1  synchronous clear of FIFO contents and overrun flag
- ErrClr  input  1  clear the Overrun, ParityErrFlag and FrameErrFlag sticky flags
- ThresholdLevel  input  DEPTH_LOG2+1  level-interrupt threshold in entries; 0 is treated as 1
- TimeoutLimit  input  16  idle cycles before TimeoutIrq (used only with the macro)
- RdData  output  8  head entry; valid whenever Empty=0
- Empty  output  1  Count==0
- Full  output  1  Count==2^DEPTH_LOG2
- Count  output  DEPTH_LOG2+1  number of stored entries
- Overrun  output  1  sticky: a byte was dropped because the FIFO was full
- ParityErrFlag  output  1  sticky parity error
- FrameErrFlag  output  1  sticky framing error
- LevelIrq  output  1  registered; Count >= max(ThresholdLevel,1)
- TimeoutIrq  output  1  registered; idle-with-data timeout

## Operation
- Storage: 2^DEPTH_LOG2 x 8 register array. Write pointer and read pointer are DEPTH_LOG2 bits wide and wrap modulo depth. Count is a separate DEPTH_LOG2+1-bit register.
- Push occurs on RxReady=1 and (Full=0 or pop this cycle). The byte is written at the write pointer and the write pointer increments.
- Pop occurs on RdEn=1 and Empty=0. The read pointer increments.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous RxReady and RdEn: both proceed. Count stays at depth and no overrun is flagged.
- Full with RxReady and no pop: the byte is dropped, Overrun sets, and FIFO contents are unchanged.
- Empty with RxReady and RdEn: push only. The RdEn is ignored, with no bypass to RdData.
- RdData is array[read pointer] (combinational read of the registered array). Its value when Empty=1 is don't-care.
- Flush takes priority over push and pop in the same cycle. It zeroes both pointers and Count and clears Overrun. A byte strobed in the Flush cycle is discarded. Flush does not touch ParityErrFlag or FrameErrFlag.
- Sticky flags: set on their event, cleared by ErrClr. When set and clear occur in the same cycle, set wins.
- LevelIrq is registered from the post-update Count.

## Timing
- Reset values:
  - pointers, Count: 0
  - Empty: 1
  - Full: 0
  - Overrun, ParityErrFlag, FrameErrFlag: 0
  - LevelIrq, TimeoutIrq: 0
  - RdData: array contents are not reset, so RdData is don't-care
- Write latency: a byte strobed in cycle N is visible on RdData, with Empty=0 and Count updated, in cycle N+1.
- Read: RdData is sampled by the bus in the RdEn cycle. The next entry appears in cycle N+1.
- LevelIrq reflects Count one cycle after Count changes, i.e. two cycles after the RxReady strobe.
- Reset asserted mid-operation clears all state immediately. RxReady pulses during reset are lost.
- Inputs ThresholdLevel and TimeoutLimit may change at any time and take effect on the next compare.

## Configuration
- Macro: UART_RX_FIFO_TIMEOUT_EN.
- When defined, a 16-bit idle counter is compiled in:
  - it is cleared on any push, pop or Flush, or while Empty=1;
  - it otherwise increments, saturating at TimeoutLimit;
  - TimeoutIrq sets in the cycle after the counter equals TimeoutLimit while Empty=0;
  - TimeoutIrq clears in the cycle after the next push, pop or Flush;
  - TimeoutLimit=0 disables the timeout, and TimeoutIrq stays 0.
- When undefined, there is no counter logic, TimeoutIrq is tied to 0, and TimeoutLimit is unconnected.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 with RdEn low -> Count=3, RdData=0x41, Empty=0. Pop three times -> RdData 0x42, then 0x43, then Empty=1, Count=0.
- DEPTH_LOG2=4: push 16 bytes 0x00..0x0F, then push 0xAA -> Full=1, Overrun=1, Count=16, pop order 0x00..0x0F, 0xAA never appears. ErrClr -> Overrun=0.
- Full FIFO with RxReady=1 and RdEn=1 in the same cycle with 0x55 -> Count stays 16, Overrun=0, 0x55 is popped last. Then Flush together with RxReady -> Count=0 and Empty=1 next cycle.
- RxParityErr pulse, then RxFrameErr pulse in the same cycle as ErrClr -> ParityErrFlag=1 then cleared. FrameErrFlag=1 (set wins). ErrClr alone -> both 0.
- ThresholdLevel=4, push 4 bytes -> LevelIrq rises 2 cycles after the 4th strobe. Pop one -> LevelIrq falls. ThresholdLevel=0 with one byte -> LevelIrq=1.
- With UART_RX_FIFO_TIMEOUT_EN and TimeoutLimit=100, push one byte and then idle -> TimeoutIrq=1 about 101 cycles after the push, and clears the cycle after RdEn. With TimeoutLimit=0 -> TimeoutIrq stays 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO with sticky error flags and level/timeout IRQs.
// Define UART_RX_FIFO_TIMEOUT_EN to build the idle-with-data timeout counter.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  RxReady,
  input  logic [7:0]            RxData,
  input  logic                  RxParityErr,
  input  logic                  RxFrameErr,
  input  logic                  RdEn,
  input  logic                  Flush,
  input  logic                  ErrClr,
  input  logic [DEPTH_LOG2:0]   ThresholdLevel,
  input  logic [15:0]           TimeoutLimit,
  output logic [7:0]            RdData,
  output logic                  Empty,
  output logic                  Full,
  output logic [DEPTH_LOG2:0]   Count,
  output logic                  Overrun,
  output logic                  ParityErrFlag,
  output logic                  FrameErrFlag,
  output logic                  LevelIrq,
  output logic                  TimeoutIrq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  level_irq_q, level_irq_d;
  logic                  empty, full, pop, push, drop;
  logic [CW-1:0]         threshold;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign pop   = RdEn & ~empty & ~Flush;
  assign push  = RxReady & (~full | (RdEn & ~empty)) & ~Flush;
  assign drop  = RxReady & full & ~RdEn;
  assign threshold = (ThresholdLevel == '0) ? CNT_ONE : ThresholdLevel;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  // Sticky flags: a set event beats ErrClr; Flush only clears the overrun flag.
  always_comb begin
    overrun_d    = overrun_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    if (ErrClr) begin
      overrun_d    = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
    end
    if (drop)        overrun_d    = 1'b1;
    if (RxParityErr) parity_err_d = 1'b1;
    if (RxFrameErr)  frame_err_d  = 1'b1;
    if (Flush)       overrun_d    = 1'b0;
    level_irq_d = (count_q >= threshold);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      level_irq_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      level_irq_q  <= level_irq_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= RxData;
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        timeout_irq_q, timeout_irq_d;
  logic        activity;

  assign activity = push | pop | Flush;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (activity || empty)             idle_cnt_d = '0;
    else if (idle_cnt_q < TimeoutLimit) idle_cnt_d = idle_cnt_q + 16'd1;
    timeout_irq_d = timeout_irq_q;
    if (TimeoutLimit == '0 || activity)             timeout_irq_d = 1'b0;
    else if (!empty && idle_cnt_q == TimeoutLimit) timeout_irq_d = 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      idle_cnt_q    <= '0;
      timeout_irq_q <= 1'b0;
    end else begin
      idle_cnt_q    <= idle_cnt_d;
      timeout_irq_q <= timeout_irq_d;
    end
  end

  assign TimeoutIrq = timeout_irq_q;
`else
  logic unused_timeout_limit;
  assign unused_timeout_limit = ^TimeoutLimit;
  assign TimeoutIrq = 1'b0;
`endif

  assign RdData        = mem_q[rd_ptr_q];
  assign Empty         = empty;
  assign Full          = full;
  assign Count         = count_q;
  assign Overrun       = overrun_q;
  assign ParityErrFlag = parity_err_q;
  assign FrameErrFlag  = frame_err_q;
  assign LevelIrq      = level_irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: scoreboard queue of accepted bytes, compared on every pop.
module tb_uart_rx_fifo;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          RxReady, RdEn, Flush, ErrClr, RxParityErr, RxFrameErr;
  logic [7:0]    RxData;
  logic [DL:0]   ThresholdLevel;
  logic [15:0]   TimeoutLimit;
  logic [7:0]    RdData;
  logic          Empty, Full, Overrun, ParityErrFlag, FrameErrFlag, LevelIrq, TimeoutIrq;
  logic [DL:0]   Count;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.DEPTH_LOG2(DL)) dut (
    .Clock(Clock), .Reset(Reset), .RxReady(RxReady), .RxData(RxData),
    .RxParityErr(RxParityErr), .RxFrameErr(RxFrameErr), .RdEn(RdEn), .Flush(Flush),
    .ErrClr(ErrClr), .ThresholdLevel(ThresholdLevel), .TimeoutLimit(TimeoutLimit),
    .RdData(RdData), .Empty(Empty), .Full(Full), .Count(Count), .Overrun(Overrun),
    .ParityErrFlag(ParityErrFlag), .FrameErrFlag(FrameErrFlag), .LevelIrq(LevelIrq),
    .TimeoutIrq(TimeoutIrq)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; results are visible #1 after the rising edge.
  task automatic step(input logic rx, input logic [7:0] d, input logic rd, input logic fl,
                      input logic ec, input logic pe, input logic fe);
    bit popping;
    @(negedge Clock);
    RxReady = rx; RxData = d; RdEn = rd; Flush = fl; ErrClr = ec;
    RxParityErr = pe; RxFrameErr = fe;
    popping = rd && !fl && (exp_q.size() > 0);
    if (popping) check("pop_data", RdData, exp_q.pop_front());
    if (fl) exp_q.delete();
    else if (rx && exp_q.size() < DEPTH) exp_q.push_back(d);
    @(posedge Clock);
    #1;
    RxReady = 0; RxData = 0; RdEn = 0; Flush = 0; ErrClr = 0; RxParityErr = 0; RxFrameErr = 0;
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0, 0, 0, 0);
  endtask
  task automatic push(input logic [7:0] d);
    step(1, d, 0, 0, 0, 0, 0);
  endtask
  task automatic pop1();
    step(0, 8'h00, 1, 0, 0, 0, 0);
  endtask
  task automatic flush();
    step(0, 8'h00, 0, 1, 0, 0, 0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, Count, exp_q.size());
    check({tag, "_empty"}, Empty, exp_q.size() == 0);
    check({tag, "_full"},  Full,  exp_q.size() == DEPTH);
    if (exp_q.size() > 0) check({tag, "_head"}, RdData, exp_q[0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    Reset = 0; RxReady = 0; RxData = 0; RdEn = 0; Flush = 0; ErrClr = 0;
    RxParityErr = 0; RxFrameErr = 0; ThresholdLevel = 5'd16; TimeoutLimit = 16'd0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_count", Count, 0);
    check("rst_empty", Empty, 1);
    check("rst_full", Full, 0);
    check("rst_flags", {Overrun, ParityErrFlag, FrameErrFlag}, 3'b000);
    check("rst_irqs", {LevelIrq, TimeoutIrq}, 2'b00);
    @(negedge Clock);
    Reset = 1;

    // Basic ordering
    push(8'h41); push(8'h42); push(8'h43);
    check_state("abc");
    check("abc_head41", RdData, 8'h41);
    pop1(); check("pop1_head", RdData, 8'h42);
    pop1(); check("pop2_head", RdData, 8'h43);
    pop1(); check_state("abc_drained");

    // Fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    check_state("fill");
    push(8'hAA);
    check_state("ovf");
    check("ovf_flag", Overrun, 1);
    for (int i = 0; i < DEPTH; i++) pop1();
    check_state("ovf_drained");
    check("ovf_sticky", Overrun, 1);
    step(0, 8'h00, 0, 0, 1, 0, 0);
    check("ovf_clr", Overrun, 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i));
    step(1, 8'h55, 1, 0, 0, 0, 0);
    check_state("full_rw");
    check("full_rw_no_ovf", Overrun, 0);
    for (int i = 0; i < DEPTH - 1; i++) pop1();
    check("last_is_55", RdData, 8'h55);
    pop1();
    check_state("full_rw_drained");

    // Flush beats a coincident strobe
    push(8'h01); push(8'h02);
    step(1, 8'h99, 0, 1, 0, 0, 0);
    check_state("flush");
    check("flush_count0", Count, 0);
    check("flush_empty", Empty, 1);

    // Sticky error flags
    step(0, 8'h00, 0, 0, 0, 1, 0);
    check("par_set", {ParityErrFlag, FrameErrFlag}, 2'b10);
    step(0, 8'h00, 0, 0, 1, 0, 1);
    check("frm_set_wins", {ParityErrFlag, FrameErrFlag}, 2'b01);
    step(0, 8'h00, 0, 0, 1, 0, 0);
    check("err_clr", {ParityErrFlag, FrameErrFlag}, 2'b00);

    // Level interrupt
    ThresholdLevel = 5'd4;
    for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
    check("lvl_not_yet", LevelIrq, 0);
    idle();
    check("lvl_rise", LevelIrq, 1);
    pop1();
    check("lvl_lag", LevelIrq, 1);
    idle();
    check("lvl_fall", LevelIrq, 0);
    flush();
    ThresholdLevel = 5'd0;
    push(8'h77);
    idle();
    check("lvl_thr0", LevelIrq, 1);
    flush();
    ThresholdLevel = 5'd16;

    // Random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 49) == 0), 0, 0, 0);
      check_state("rnd");
    end
    while (exp_q.size() > 0) pop1();
    check_state("rnd_drained");
    step(0, 8'h00, 0, 0, 1, 0, 0);

    // Idle-with-data timeout
    TimeoutLimit = 16'd100;
    push(8'h11);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    n = 0;
    while (!TimeoutIrq && n < 300) begin
      idle();
      n++;
    end
    check("tmo_cycles", n, 101);
    pop1();
    check("tmo_clear", TimeoutIrq, 0);
    TimeoutLimit = 16'd0;
    push(8'h12);
`endif
    seen = 0;
    repeat (150) begin
      idle();
      if (TimeoutIrq) seen = 1;
    end
    check("tmo_off", seen, 0);

    // Asynchronous reset mid-operation; a strobe during reset is lost
    push(8'h31); push(8'h32);
    @(negedge Clock);
    Reset = 0;
    #1;
    check("arst_count", Count, 0);
    check("arst_empty", Empty, 1);
    RxReady = 1; RxData = 8'hEE;
    @(posedge Clock);
    #1;
    RxReady = 0;
    exp_q.delete();
    check("arst_lost", Count, 0);
    @(negedge Clock);
    Reset = 1;
    idle();
    check_state("after_arst");
    check("after_arst_lvl", LevelIrq, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
